// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2:1 mux, with a one-entry registered output stage.
// Define MUX_ARB_LOCK_EN to add lock_a/lock_b, which keep the current grant past the MAX_HOLD cap.
//   state | meaning
//   IDLE  | no grant, no ready asserted
//   GNT_A | A owns the mux (sel=0)
//   GNT_B | B owns the mux (sel=1)
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic             lock_a,
  input  logic             lock_b
`endif
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_SW  = CW'(MAX_HOLD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic out_free, xfer_a, xfer_b, cap_hit, hold_a, hold_b, go_a, go_b;

`ifdef MUX_ARB_LOCK_EN
  assign hold_a = lock_a;
  assign hold_b = lock_b;
`else
  assign hold_a = 1'b0;
  assign hold_b = 1'b0;
`endif

  assign out_free  = !out_valid_q | out_ready;
  assign a_ready   = (state_q == GNT_A) & out_free;
  assign b_ready   = (state_q == GNT_B) & out_free;
  assign xfer_a    = a_valid & a_ready;
  assign xfer_b    = b_valid & b_ready;
  assign cap_hit   = (cnt_q >= CNT_SW);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    go_a    = 1'b0;
    go_b    = 1'b0;
    if ((xfer_a | xfer_b) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
    case (state_q)
      // last_q=1 means B was served most recently, so A wins a tie
      IDLE: begin
        if (a_valid && (!b_valid || last_q)) go_a = 1'b1;
        else if (b_valid)                    go_b = 1'b1;
      end
      GNT_A: begin
        if (!a_valid) begin
          if (b_valid) go_b = 1'b1;
          else         state_d = IDLE;
        end else if (xfer_a && cap_hit && b_valid && !hold_a) begin
          go_b = 1'b1;
        end
      end
      GNT_B: begin
        if (!b_valid) begin
          if (a_valid) go_a = 1'b1;
          else         state_d = IDLE;
        end else if (xfer_b && cap_hit && a_valid && !hold_b) begin
          go_a = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_a) begin
      state_d = GNT_A;
      sel_d   = 1'b0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end else if (go_b) begin
      state_d = GNT_B;
      sel_d   = 1'b1;
      last_d  = 1'b1;
      cnt_d   = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer_a) begin
      out_valid_d = 1'b1;
      out_data_d  = a_data;
    end else if (xfer_b) begin
      out_valid_d = 1'b1;
      out_data_d  = b_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
